vxe_intr_msg: RTL and testbench

- Downstream neighbour of the interrupt unit. Consumes its per-source active vector (raw & ~mask) and turns it into message-signalled interrupts (MSI-style) for the host bus master.
- Latches rising edges of active sources and batches them into one message vector.
- Sends the message over a valid/ready handshake.
- Enforces a programmable hold-off between consecutive messages so bursts of completions coalesce.

---
 rtl/vxe_intr_msg_pkg.sv | 13 +
 rtl/vxe_edge_det.sv | 21 ++
 rtl/vxe_intr_msg.sv | 87 ++++++++
 tb/tb_vxe_intr_msg.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vxe_intr_msg_pkg.sv
// Shared types for the interrupt message path: FSM encoding and default sizes.
package vxe_intr_msg_pkg;

   localparam int NR_INT_DEF = 4;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/vxe_edge_det.sv
// Registered rising-edge detector over a vector; a bit already high in the
// first cycle after reset is reported as an edge.
module vxe_edge_det #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] rise
);

   logic [W-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (rst) prev_q <= '0;
      else     prev_q <= din;
   end

   assign rise = din & ~prev_q;

endmodule

// File: rtl/vxe_intr_msg.sv
// Turns active interrupt sources into batched MSI-style messages with a
// programmable hold-off between messages so bursts coalesce.
module vxe_intr_msg
   import vxe_intr_msg_pkg::*;
#(
   parameter int NR_INT = NR_INT_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NR_INT-1:0] i_active,
   input  logic              i_cfg_en,
   input  logic [CNT_W-1:0]  i_holdoff,
   output logic              o_msg_valid,
   output logic [NR_INT-1:0] o_msg_vec,
   input  logic              i_msg_ready,
   output logic [NR_INT-1:0] o_pending,
   output logic              o_busy
);

   state_e              state_q, state_d;
   logic [NR_INT-1:0]   rise, pend_q, msg_q, clr;
   logic [CNT_W-1:0]    cnt_q;
   logic                load_msg, load_cnt;

   vxe_edge_det #(.W(NR_INT)) u_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (i_active),
      .rise (rise)
   );

   always_comb begin
      state_d     = state_q;
      clr         = '0;
      load_msg    = 1'b0;
      load_cnt    = 1'b0;
      o_msg_valid = 1'b0;
      o_msg_vec   = '0;
      case (state_q)
         IDLE: begin
            if (i_cfg_en && (pend_q != '0)) begin
               load_msg = 1'b1;
               clr      = pend_q;
               state_d  = SEND;
            end
         end
         SEND: begin
            o_msg_valid = 1'b1;
            o_msg_vec   = msg_q;
            if (i_msg_ready) begin
               if (i_holdoff == '0) begin
                  state_d = IDLE;
               end else begin
                  load_cnt = 1'b1;
                  state_d  = HOLD;
               end
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Edges arriving in the capture cycle are OR-ed in after the clear, so they
   // stay pending for the next message.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         msg_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= (pend_q & ~clr) | rise;
         if (load_msg) msg_q <= pend_q;
         if (load_cnt)               cnt_q <= i_holdoff;
         else if (state_q == HOLD)   cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign o_pending = pend_q;
   assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vxe_intr_msg.sv
// Randomized bench for vxe_intr_msg against a timestamp-based reference model.
module tb_vxe_intr_msg;

   localparam int NR_INT = 4;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR_INT-1:0] act;
   logic              en;
   logic [CNT_W-1:0]  holdoff;
   logic              ready;
   logic              msg_valid;
   logic [NR_INT-1:0] msg_vec;
   logic [NR_INT-1:0] pending;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // Model: pending set, message in flight, and the cycle from which the
   // block is free to capture again.
   logic [NR_INT-1:0] m_prev, m_pend, m_vec;
   bit                m_fly;
   longint            cyc, idle_at;

   vxe_intr_msg #(.NR_INT(NR_INT), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_active    (act),
      .i_cfg_en    (en),
      .i_holdoff   (holdoff),
      .o_msg_valid (msg_valid),
      .o_msg_vec   (msg_vec),
      .i_msg_ready (ready),
      .o_pending   (pending),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick;
      logic [NR_INT-1:0] rise, clr;
      @(posedge clk);
      rise = act & ~m_prev;
      clr  = '0;
      if (rst) begin
         m_prev  = '0;
         m_pend  = '0;
         m_vec   = '0;
         m_fly   = 1'b0;
         idle_at = cyc + 1;
      end else begin
         m_prev = act;
         if (m_fly) begin
            if (ready) begin
               m_fly   = 1'b0;
               idle_at = cyc + 1 + longint'(holdoff);
            end
         end else if (cyc >= idle_at && en && m_pend != '0) begin
            m_fly = 1'b1;
            m_vec = m_pend;
            clr   = m_pend;
         end
         m_pend = (m_pend & ~clr) | rise;
      end
      cyc++;
      #1;
      check("valid",   32'(msg_valid), 32'(m_fly));
      check("vec",     32'(msg_vec),   m_fly ? 32'(m_vec) : 32'd0);
      check("pending", 32'(pending),   32'(m_pend));
      check("busy",    32'(busy),      32'(m_fly || (cyc < idle_at)));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      m_prev = '0; m_pend = '0; m_vec = '0; m_fly = 1'b0;
      cyc = 0; idle_at = 0;
      rst = 1'b1; act = '0; en = 1'b1; holdoff = '0; ready = 1'b1;
      ticks(2);
      rst = 1'b0;

      // single edge, ready tied high, no hold-off
      ticks(3);
      act = 4'b0001;
      ticks(5);
      act = 4'b0000;

      // back-pressure with enable dropped mid-wait
      ready = 1'b0;
      act = 4'b0010;
      ticks(3);
      en = 1'b0;
      ticks(9);
      ready = 1'b1;
      ticks(2);
      en = 1'b1; act = 4'b0000;

      // coalescing during hold-off
      holdoff = 16'd8;
      act = 4'b0001;
      ticks(3);
      act = 4'b0101; ticks(1);
      act = 4'b1101; ticks(1);
      holdoff = 16'd2; ticks(12);
      act = '0; holdoff = '0; ticks(3);

      // capture collision: new edge on an already-pending bit
      en = 1'b0;
      act = 4'b0010; ticks(1);
      act = 4'b0000; ticks(1);
      en = 1'b1; act = 4'b0010; ticks(6);
      act = '0; ticks(2);

      // disabled delivery
      en = 1'b0;
      act = 4'b0011; ticks(4);
      en = 1'b1; ticks(4);
      act = '0; ticks(2);

      // reset while a message is in flight
      ready = 1'b0;
      act = 4'b0001; ticks(3);
      rst = 1'b1; ticks(2);
      rst = 1'b0; ticks(4);
      ready = 1'b1; ticks(2);
      act = '0; ticks(2);

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0) act = NR_INT'($urandom);
         ready   = ($urandom_range(0, 2) != 0);
         en      = ($urandom_range(0, 7) != 0);
         holdoff = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
         if (i == 1200) holdoff = CNT_W'(1);
         rst     = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      ticks(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
